// File: rtl/alu_sequencer.sv
// Issue/writeback controller for the combinational ALU: one instruction in flight, operands from a local register file.
// Optional macro ALU_SEQ_MUL_HI_WB_EN adds a second writeback cycle for the high half of a multiply.
module alu_sequencer #(
    parameter int         DATA_WIDTH = 8,
    parameter int         SHIFT_BITS = $clog2(DATA_WIDTH),
    parameter int         NUM_REGS   = 8,
    parameter int         REG_ADDR_W = $clog2(NUM_REGS),
    parameter logic [4:0] MUL_OPCODE = 5'b00011
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [4:0]              instr_opcode,
    input  logic [REG_ADDR_W-1:0]   instr_rd,
    input  logic [REG_ADDR_W-1:0]   instr_rs1,
    input  logic [REG_ADDR_W-1:0]   instr_rs2,
    input  logic [SHIFT_BITS-1:0]   instr_shamt,
    input  logic [DATA_WIDTH-1:0]   instr_imm,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [4:0]              alu_opcode,
    output logic [SHIFT_BITS-1:0]   alu_shift_amount,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic                    alu_carry_out,
    input  logic [2*DATA_WIDTH-1:0] alu_mult_result,
    output logic                    carry_flag,
    output logic                    done,
    input  logic [REG_ADDR_W-1:0]   dbg_addr,
    output logic [DATA_WIDTH-1:0]   dbg_data
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] EXEC       = 2'd1;
`ifdef ALU_SEQ_MUL_HI_WB_EN
    localparam logic [1:0] WB_HI      = 2'd2;
`endif
    localparam logic [1:0] UNIT_LOCAL = 2'b11;
    localparam logic [4:0] LDI_OPCODE = 5'b11000;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  cls_alu;
    logic                  cls_ldi;
    logic                  accept;

`ifdef ALU_SEQ_MUL_HI_WB_EN
    logic                  cls_mul;
    logic [DATA_WIDTH-1:0] hold;
`else
    // Without the high-half writeback the full product and the multiply opcode have no consumer.
    logic                  mult_unused;
    assign mult_unused = ^{alu_mult_result, MUL_OPCODE};
`endif

    assign instr_ready = (state == IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign dbg_data    = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            regs             <= '{default: '0};
            alu_a            <= '0;
            alu_b            <= '0;
            alu_opcode       <= '0;
            alu_shift_amount <= '0;
            carry_flag       <= 1'b0;
            done             <= 1'b0;
            rd_q             <= '0;
            imm_q            <= '0;
            cls_alu          <= 1'b0;
            cls_ldi          <= 1'b0;
`ifdef ALU_SEQ_MUL_HI_WB_EN
            cls_mul          <= 1'b0;
            hold             <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a            <= regs[instr_rs1];
                        alu_b            <= regs[instr_rs2];
                        alu_opcode       <= instr_opcode;
                        alu_shift_amount <= instr_shamt;
                        rd_q             <= instr_rd;
                        imm_q            <= instr_imm;
                        cls_alu          <= (instr_opcode[4:3] != UNIT_LOCAL);
                        cls_ldi          <= (instr_opcode == LDI_OPCODE);
`ifdef ALU_SEQ_MUL_HI_WB_EN
                        cls_mul          <= (instr_opcode == MUL_OPCODE);
`endif
                        state            <= EXEC;
                    end
                end
                EXEC: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (cls_alu) begin
                        carry_flag <= alu_carry_out;
`ifdef ALU_SEQ_MUL_HI_WB_EN
                        // Multiply retires one cycle later, after the high half lands in rd+1.
                        if (cls_mul) begin
                            regs[rd_q] <= alu_mult_result[DATA_WIDTH-1:0];
                            hold       <= alu_mult_result[2*DATA_WIDTH-1:DATA_WIDTH];
                            state      <= WB_HI;
                            done       <= 1'b0;
                        end else begin
                            regs[rd_q] <= alu_result;
                        end
`else
                        regs[rd_q] <= alu_result;
`endif
                    end else if (cls_ldi) begin
                        regs[rd_q] <= imm_q;
                    end
                end
`ifdef ALU_SEQ_MUL_HI_WB_EN
                WB_HI: begin
                    regs[rd_q + REG_ADDR_W'(1)] <= hold;
                    state <= IDLE;
                    done  <= 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequential issue/writeback controller that drives the parameterized ALU from the initiator side. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file. It presents registered operands, opcode and shift amount to the ALU, then captures the ALU outputs and writes them back to the register file. It sits between the instruction source (test harness or future decoder) and the combinational ALU.

## Interface
- DATA_WIDTH, 8, operand/register width; must match the ALU
- SHIFT_BITS, $clog2(DATA_WIDTH), shift amount width
- NUM_REGS, 8, register file depth; power of two, at least 2
- REG_ADDR_W, $clog2(NUM_REGS), register index width
- MUL_OPCODE, 5'b00011, ALU opcode treated as multiply

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction present
- instr_ready  output  1  sequencer can accept
- instr_opcode  input  5  {unit[1:0], op[2:0]}; unit 2'b11 is local: 5'b11000 = LDI, other 11xxx = NOP
- instr_rd / instr_rs1 / instr_rs2  input  REG_ADDR_W each  destination and source registers
- instr_shamt  input  SHIFT_BITS  shift amount
- instr_imm  input  DATA_WIDTH  LDI immediate
- alu_a, alu_b  output  DATA_WIDTH each  registered operands to the ALU
- alu_opcode  output  5  registered opcode to the ALU
- alu_shift_amount  output  SHIFT_BITS  registered shift amount
- alu_result  input  DATA_WIDTH  from the ALU
- alu_carry_out  input  1  from the ALU
- alu_mult_result  input  2*DATA_WIDTH  from the ALU
- carry_flag  output  1  carry from the last ALU-unit instruction
- done  output  1  one-cycle pulse on instruction retire
- dbg_addr  input  REG_ADDR_W  debug read index
- dbg_data  output  DATA_WIDTH  combinational read of regs[dbg_addr]

## Operation
- FSM states:
  - IDLE: instr_ready=1 when rst=0.
  - EXEC: the ALU evaluates the registered operands; writeback happens at the end of this state.
  - WB_HI: multiply high-half writeback.
- Accept: instr_valid & instr_ready at an edge. On that edge:
  - alu_a <= regs[rs1], alu_b <= regs[rs2], alu_opcode <= opcode, alu_shift_amount <= shamt.
  - rd, imm and the opcode class are latched.
  - State goes to EXEC.
- EXEC edge, by opcode class:
  - Unit 00/01/10: regs[rd] <= alu_result; carry_flag <= alu_carry_out.
  - LDI: regs[rd] <= imm; carry_flag unchanged.
  - NOP: no write; carry_flag unchanged.
  - Opcode == MUL_OPCODE (with the macro enabled): regs[rd] <= alu_mult_result[DATA_WIDTH-1:0]; hi half is captured into a hold register; next state is WB_HI. All other cases go to IDLE with done=1.
- WB_HI edge: regs[(rd+1) mod NUM_REGS] <= hold; next state IDLE; done=1.
- Operand reads at accept see all earlier writebacks. There are no hazards because only one instruction is in flight.
- All registers are writable, including r0. Index arithmetic wraps modulo NUM_REGS.
- instr_valid is ignored while instr_ready=0. The source must hold its fields stable until the handshake completes.

## Timing
- Reset (rst high at an edge):
  - State IDLE; all regs 0.
  - alu_a, alu_b, alu_opcode, alu_shift_amount 0; carry_flag 0; done 0.
  - instr_ready is 0 while rst=1.
- Reset takes priority mid-operation: a pending EXEC or WB_HI write is discarded.
- Non-multiply instruction:
  - Accepted at edge T; regs and carry_flag updated at T+1; done high during cycle T+1.
  - instr_ready high again in cycle T+1, so the next accept is at T+2.
  - Throughput is one instruction per 2 cycles.
- Multiply (macro on): lo written at T+1, hi at T+2; done high in cycle T+2; next accept at T+3.
- dbg_data reflects a write in the cycle after the writing edge.

## Configuration
- ALU_SEQ_MUL_HI_WB_EN:
  - Defined: WB_HI state and hold register are present; multiply writes the full 2*DATA_WIDTH product as lo->rd, hi->rd+1 with a 3-cycle occupancy.
  - Undefined: WB_HI and the hold register are removed; multiply writes only the low half to rd and behaves like any other ALU instruction (2-cycle occupancy).
  - alu_mult_result is unused when the macro is undefined.

## Test plan
Bench instantiates the sequencer with the ALU (DATA_WIDTH=8, ADD=5'b00000, MUL=5'b00011) and the macro defined unless stated.
- Reset: rst for 2 cycles -> every dbg_data read 0, carry_flag 0, done 0, instr_ready 1 in the first cycle after rst drops.
- LDI r1=0xF0, LDI r2=0x20, ADD rd=3,rs1=1,rs2=2 -> r3=0x10, carry_flag=1, done pulsed exactly 1 cycle after each accept.
- MUL rd=7,rs1=1,rs2=2 (0xF0*0x20=0x1E00) -> r7=0x00, r0=0x1E (index wrap), instr_ready low for 2 cycles; repeat with the macro undefined -> r7=0x00, r0 unchanged, instr_ready low 1 cycle.
- instr_valid held high with LDI, MUL, NOP queued -> accepts at cycles 0, 2, 5; NOP 5'b11111 leaves all regs and carry_flag unchanged but still pulses done.
- rst asserted in the WB_HI cycle of a MUL -> hi half not written, all regs 0 and state IDLE after the edge, no done pulse.
